gpr_mp: RTL and testbench

- Next-generation general-purpose register file for the CPU core.
- Parametrised in data width, depth and number of combinational read ports.
- Two write ports with per-byte enables, same-cycle write-to-read bypass, optional hardwired-zero r0.
- Background clear engine that zeroes the file one register per cycle on request, without a core reset.

---
 rtl/gpr_mp.sv | 128 ++++++++++++
 tb/tb_gpr_mp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_mp.sv
// General-purpose register file: NUM_RD combinational read ports, two byte-enabled
// write ports with optional same-cycle bypass, and a one-register-per-cycle clear sweep.
module gpr_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W/8-1:0]      wr0_be,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W/8-1:0]      wr1_be,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     wr_conflict,
   output logic                     wr_dropped
);

   localparam int                NB       = DATA_W / 8;
   localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic                clr_busy_q;
   logic                clr_done_q;
   logic                wr_conflict_q;
   logic                wr_dropped_q;
   logic [DATA_W-1:0]   gpr_q   [NUM_REGS];
   logic [DATA_W-1:0]   gpr_d   [NUM_REGS];
   logic [DATA_W-1:0]   wr_view [NUM_REGS];
   logic                wr0_ok;
   logic                wr1_ok;

   // Address names an implemented, writable/readable register (r0 excluded when hardwired).
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   assign wr0_ok = wr0_en && addr_ok(wr0_addr) && !clr_busy_q;
   assign wr1_ok = wr1_en && addr_ok(wr1_addr) && !clr_busy_q;

   // wr_view is each register as it stands after this cycle's port writes (port 1 last,
   // so it wins on shared lanes); gpr_d additionally applies the sweep's clear.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_view[i] = gpr_q[i];
         for (int b = 0; b < NB; b++) begin
            if (wr0_ok && (wr0_addr == ADDR_W'(i)) && wr0_be[b])
               wr_view[i][b*8 +: 8] = wr0_data[b*8 +: 8];
            if (wr1_ok && (wr1_addr == ADDR_W'(i)) && wr1_be[b])
               wr_view[i][b*8 +: 8] = wr1_data[b*8 +: 8];
         end
         gpr_d[i] = (clr_busy_q && (ptr_q == ADDR_W'(i))) ? '0 : wr_view[i];
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [IDX_W-1:0]  ri;
      assign ra = rd_addr[k*ADDR_W +: ADDR_W];
      assign ri = ra[IDX_W-1:0];
      assign rd_data[k*DATA_W +: DATA_W] = !addr_ok(ra)  ? '0 :
                                           (BYPASS != 0) ? wr_view[ri] : gpr_q[ri];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= gpr_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         clr_busy_q    <= 1'b0;
         clr_done_q    <= 1'b0;
         wr_conflict_q <= 1'b0;
         wr_dropped_q  <= 1'b0;
      end else begin
         clr_done_q    <= 1'b0;
         wr_conflict_q <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
         wr_dropped_q  <= (wr0_en && !wr0_ok) || (wr1_en && !wr1_ok);
         case (state_q)
            IDLE: begin
               if (clr_req) begin
                  state_q    <= CLEAR;
                  ptr_q      <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (ptr_q == LAST_PTR) begin
                  state_q    <= IDLE;
                  clr_busy_q <= 1'b0;
                  clr_done_q <= 1'b1;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clr_busy    = clr_busy_q;
   assign clr_done    = clr_done_q;
   assign wr_conflict = wr_conflict_q;
   assign wr_dropped  = wr_dropped_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: a bypassing and a non-bypassing instance share stimulus and are
// compared every cycle against a behavioural register-file model.
module tb_gpr_mp;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int NR = 32;
   localparam int RD = 2;

   logic            clk;
   logic            reset;
   logic [RD*AW-1:0] rd_addr;
   logic [RD*DW-1:0] rdb, rdn;
   logic            wr0_en, wr1_en;
   logic [AW-1:0]   wr0_addr, wr1_addr;
   logic [3:0]      wr0_be, wr1_be;
   logic [DW-1:0]   wr0_data, wr1_data;
   logic            clr_req;
   logic            busy_b, done_b, conf_b, drop_b;
   logic            busy_n, done_n, conf_n, drop_n;

   gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD), .ZERO_REG(1), .BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdb),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_be(wr0_be), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_be(wr1_be), .wr1_data(wr1_data),
      .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b),
      .wr_conflict(conf_b), .wr_dropped(drop_b));

   gpr_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD), .ZERO_REG(1), .BYPASS(0)) u_nob (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdn),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_be(wr0_be), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_be(wr1_be), .wr1_data(wr1_data),
      .clr_req(clr_req), .clr_busy(busy_n), .clr_done(done_n),
      .wr_conflict(conf_n), .wr_dropped(drop_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [NR];
   bit          m_busy, m_done, m_conf, m_drop;
   int          m_ptr;

   function automatic bit m_valid(input logic en, input logic [AW-1:0] a);
      return en && (int'(a) < NR) && (a != 0) && !m_busy;
   endfunction

   function automatic logic [31:0] m_read(input logic [AW-1:0] a, input bit byp);
      logic [31:0] v;
      if (int'(a) >= NR || a == 0) return 32'h0;
      v = m_mem[a];
      if (byp) begin
         for (int b = 0; b < 4; b++) begin
            if (m_valid(wr0_en, wr0_addr) && wr0_addr == a && wr0_be[b]) v[b*8 +: 8] = wr0_data[b*8 +: 8];
            if (m_valid(wr1_en, wr1_addr) && wr1_addr == a && wr1_be[b]) v[b*8 +: 8] = wr1_data[b*8 +: 8];
         end
      end
      return v;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NR; i++) m_mem[i] = 32'h0;
         m_busy = 0; m_done = 0; m_conf = 0; m_drop = 0; m_ptr = 0;
      end else begin
         bit v0, v1;
         v0 = m_valid(wr0_en, wr0_addr);
         v1 = m_valid(wr1_en, wr1_addr);
         m_drop = (wr0_en && !v0) || (wr1_en && !v1);
         m_conf = wr0_en && wr1_en && (wr0_addr == wr1_addr);
         for (int b = 0; b < 4; b++) begin
            if (v0 && wr0_be[b]) m_mem[wr0_addr][b*8 +: 8] = wr0_data[b*8 +: 8];
            if (v1 && wr1_be[b]) m_mem[wr1_addr][b*8 +: 8] = wr1_data[b*8 +: 8];
         end
         if (m_busy) begin
            m_mem[m_ptr] = 32'h0;
            m_done = (m_ptr == NR - 1);
            if (m_done) m_busy = 0;
            else m_ptr = m_ptr + 1;
         end else begin
            m_done = 0;
            if (clr_req) begin
               m_busy = 1;
               m_ptr  = 0;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < RD; k++) begin
            chk("rd_byp", rdb[k*DW +: DW], m_read(rd_addr[k*AW +: AW], 1'b1));
            chk("rd_nobyp", rdn[k*DW +: DW], m_read(rd_addr[k*AW +: AW], 1'b0));
         end
         chk("clr_busy", {31'b0, busy_b}, {31'b0, m_busy});
         chk("clr_busy_n", {31'b0, busy_n}, {31'b0, m_busy});
         chk("clr_done", {31'b0, done_b}, {31'b0, m_done});
         chk("clr_done_n", {31'b0, done_n}, {31'b0, m_done});
         chk("wr_conflict", {31'b0, conf_b}, {31'b0, m_conf});
         chk("wr_conflict_n", {31'b0, conf_n}, {31'b0, m_conf});
         chk("wr_dropped", {31'b0, drop_b}, {31'b0, m_drop});
         chk("wr_dropped_n", {31'b0, drop_n}, {31'b0, m_drop});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wr0_en = 0; wr1_en = 0; clr_req = 0;
   endtask

   task automatic set_wr0(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
      wr0_en = 1; wr0_addr = a; wr0_be = be; wr0_data = d;
   endtask

   task automatic set_wr1(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
      wr1_en = 1; wr1_addr = a; wr1_be = be; wr1_data = d;
   endtask

   function automatic logic [31:0] fill_val(input int i);
      return 32'h1000_0001 + 32'(i) * 32'h0001_0101;
   endfunction

   task automatic fill_all();
      for (int i = 0; i < NR / 2; i++) begin
         set_wr0(AW'(2 * i), 4'hF, fill_val(2 * i));
         set_wr1(AW'(2 * i + 1), 4'hF, fill_val(2 * i + 1));
         tick();
      end
      idle_in();
   endtask

   task automatic all_zero(input string nm);
      for (int a = 0; a < NR; a += 2) begin
         rd_addr = {AW'(a + 1), AW'(a)};
         @(negedge clk);
         chk(nm, rdb[31:0], 32'h0);
         chk(nm, rdb[63:32], 32'h0);
         tick();
      end
   endtask

   int busy_cnt, done_cnt;

   initial begin
      reset = 1; rd_addr = '0; clr_req = 0;
      wr0_en = 0; wr0_addr = '0; wr0_be = '0; wr0_data = '0;
      wr1_en = 0; wr1_addr = '0; wr1_be = '0; wr1_data = '0;
      tick(); tick();
      reset = 0; chk_en = 1;
      all_zero("reset_read");

      // r5 write, bypass visible the same cycle only on the bypassing instance
      set_wr0(6'd5, 4'hF, 32'hDEADBEEF); rd_addr = {6'd0, 6'd5};
      @(negedge clk);
      chk("r5_bypass", rdb[31:0], 32'hDEADBEEF);
      chk("r5_nobypass", rdn[31:0], 32'h0);
      tick(); idle_in();
      @(negedge clk);
      chk("r5_stored", rdb[31:0], 32'hDEADBEEF);
      chk("r5_stored_n", rdn[31:0], 32'hDEADBEEF);

      // partial byte-enable write with bypass
      tick(); set_wr0(6'd3, 4'hF, 32'h11223344);
      tick(); set_wr0(6'd3, 4'b0011, 32'hAAAABBBB); rd_addr = {6'd0, 6'd3};
      @(negedge clk);
      chk("r3_bypass", rdb[31:0], 32'h1122BBBB);
      chk("r3_nobypass", rdn[31:0], 32'h11223344);
      tick(); idle_in();
      @(negedge clk);
      chk("r3_stored", rdb[31:0], 32'h1122BBBB);
      chk("r3_stored_n", rdn[31:0], 32'h1122BBBB);

      // same-address writes on both ports
      tick(); set_wr0(6'd7, 4'hF, 32'h000000FF); set_wr1(6'd7, 4'b0001, 32'h00000011);
      tick(); idle_in(); rd_addr = {6'd7, 6'd7};
      @(negedge clk);
      chk("r7_overlap", rdb[31:0], 32'h00000011);
      chk("conflict_1", {31'b0, conf_b}, 32'h1);
      tick();
      @(negedge clk);
      chk("conflict_pulse", {31'b0, conf_b}, 32'h0);
      tick(); set_wr0(6'd7, 4'hF, 32'h000000FF); set_wr1(6'd7, 4'b1000, 32'h22000000);
      tick(); idle_in();
      @(negedge clk);
      chk("r7_merge", rdn[31:0], 32'h220000FF);
      chk("conflict_2", {31'b0, conf_b}, 32'h1);

      // discarded writes: hardwired r0 and out-of-range address
      tick(); set_wr0(6'd0, 4'hF, 32'h12345678);
      tick(); idle_in(); rd_addr = {6'd0, 6'd0};
      @(negedge clk);
      chk("r0_zero", rdb[31:0], 32'h0);
      chk("drop_r0", {31'b0, drop_b}, 32'h1);
      tick(); set_wr1(6'd40, 4'hF, 32'hCAFEF00D);
      tick(); idle_in(); rd_addr = {6'd40, 6'd40};
      @(negedge clk);
      chk("r40_zero", rdb[63:32], 32'h0);
      chk("drop_r40", {31'b0, drop_b}, 32'h1);
      tick();

      // full clear sweep with a write and a read of r31 mid-sweep
      fill_all();
      clr_req = 1; tick(); clr_req = 0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         idle_in();
         if (c == 5) begin
            set_wr0(6'd20, 4'hF, 32'h55555555);
            rd_addr = {6'd0, 6'd31};
         end
         @(negedge clk);
         if (busy_b) busy_cnt++;
         if (done_b) done_cnt++;
         if (c == 5) chk("r31_mid_sweep", rdb[31:0], fill_val(31));
         if (c == 6) chk("drop_mid_sweep", {31'b0, drop_b}, 32'h1);
         tick();
      end
      chk("sweep_len", 32'(busy_cnt), 32'd32);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      all_zero("after_sweep");

      // reset in the middle of a sweep
      fill_all();
      clr_req = 1; tick(); clr_req = 0;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 10) reset = 1;
         if (c == 11) reset = 0;
         @(negedge clk);
         if (done_b) done_cnt++;
         if (c == 11) chk("busy_after_reset", {31'b0, busy_b}, 32'h0);
         tick();
      end
      chk("no_done_after_reset", 32'(done_cnt), 32'd0);
      all_zero("after_reset");

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         wr0_en   = ($urandom_range(0, 1) == 1);
         wr0_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 31));
         wr0_be   = 4'($urandom_range(0, 15));
         wr0_data = $urandom;
         wr1_en   = ($urandom_range(0, 1) == 1);
         wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, 35));
         wr1_be   = 4'($urandom_range(0, 15));
         wr1_data = $urandom;
         clr_req  = ($urandom_range(0, 59) == 0);
         reset    = ($urandom_range(0, 399) == 0);
         rd_addr[AW-1:0]    = ($urandom_range(0, 2) == 0) ? wr0_addr : AW'($urandom_range(0, 40));
         rd_addr[2*AW-1:AW] = ($urandom_range(0, 2) == 0) ? wr1_addr : AW'($urandom_range(0, 63));
         @(negedge clk);
         tick();
      end
      reset = 0; idle_in();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
